// File: rtl/seven_seg_pkg.sv
// Shared constants for the 7-segment read-back path: segment codes (active-low {CG..CA}),
// special BCD values and the capture FSM state encoding.
`timescale 1ns/1ps
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1011000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam logic [3:0] BCD_ERR   = 4'hE;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } capture_state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decoder from an active-low segment pattern back to a BCD nibble;
// blank maps to BCD_BLANK, anything unrecognised to BCD_ERR.
`timescale 1ns/1ps
module seg7_to_bcd
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd
);

    always_comb begin
        bcd = BCD_ERR;
        case (seg)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: bcd = BCD_BLANK;
            default:   bcd = BCD_ERR;
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Samples a multiplexed 7-segment bus, waits for each digit to be stable, decodes it
// back to BCD and publishes an 8-digit frame once every anode has been captured.
`timescale 1ns/1ps
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_in,
    input  logic [7:0]  an_in,
    output logic [31:0] digits,
    output logic        frame_done,
    output logic        frame_err,
    output logic        pattern_err,
    output logic [2:0]  cur_digit
);

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0] CNT_PRE  = 8'(STABLE_CYCLES - 2);

    logic [6:0]     seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d, seg_prev_q, seg_prev_d;
    logic [7:0]     an_s1_q, an_s1_d, an_s2_q, an_s2_d, an_prev_q, an_prev_d;
    capture_state_t state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [31:0]    shadow_q, shadow_d;
    logic [7:0]     seen_q, seen_d;
    logic [31:0]    digits_q, digits_d;
    logic           frame_done_q, frame_done_d;
    logic           frame_err_q, frame_err_d;
    logic           pattern_err_q, pattern_err_d;
    logic [2:0]     cur_digit_q, cur_digit_d;

    logic [7:0]     an_low;
    logic           anode_valid;
    logic           changed;
    logic           capture;
    logic [2:0]     idx;
    logic [3:0]     nib;
    logic [31:0]    merged;
    logic [7:0]     seen_next;
    logic           merged_err;

    seg7_to_bcd u_dec (
        .seg (seg_s2_q),
        .bcd (nib)
    );

    always_comb begin
        seg_s1_d   = seg_in;
        seg_s2_d   = seg_s1_q;
        seg_prev_d = seg_s2_q;
        an_s1_d    = an_in;
        an_s2_d    = an_s1_q;
        an_prev_d  = an_s2_q;

        // A digit is only meaningful when exactly one anode is pulled low.
        an_low      = ~an_s2_q;
        anode_valid = (an_low != 8'd0) && ((an_low & (an_low - 8'd1)) == 8'd0);
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (an_low[i]) idx = 3'(i);
        end
        changed = (seg_s2_q != seg_prev_q) || (an_s2_q != an_prev_q);

        state_d       = state_q;
        cnt_d         = cnt_q;
        capture       = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (anode_valid) state_d = SETTLE;
            end
            SETTLE: begin
                if (!anode_valid) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (changed) begin
                    cnt_d = 8'd0;
                end else if (cnt_q >= CNT_PRE) begin
                    cnt_d   = CNT_LAST;
                    capture = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HOLD: begin
                if (changed) begin
                    cnt_d   = 8'd0;
                    state_d = anode_valid ? SETTLE : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        merged = shadow_q;
        merged[{idx, 2'b00} +: 4] = nib;
        seen_next  = seen_q | (8'b1 << idx);
        merged_err = 1'b0;
        for (int i = 0; i < 8; i++) begin
            merged_err = merged_err | (merged[i*4 +: 4] == BCD_ERR);
        end

        shadow_d      = shadow_q;
        seen_d        = seen_q;
        digits_d      = digits_q;
        frame_err_d   = frame_err_q;
        cur_digit_d   = cur_digit_q;
        frame_done_d  = 1'b0;
        pattern_err_d = 1'b0;

        // The completing capture publishes the merged frame; shadow keeps its contents.
        if (capture) begin
            shadow_d      = merged;
            cur_digit_d   = idx;
            pattern_err_d = (nib == BCD_ERR);
            if (seen_next == 8'hFF) begin
                digits_d     = merged;
                frame_err_d  = merged_err;
                frame_done_d = 1'b1;
                seen_d       = 8'd0;
            end else begin
                seen_d = seen_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_s1_q      <= 7'h7F;
            seg_s2_q      <= 7'h7F;
            seg_prev_q    <= 7'h7F;
            an_s1_q       <= 8'hFF;
            an_s2_q       <= 8'hFF;
            an_prev_q     <= 8'hFF;
            state_q       <= IDLE;
            cnt_q         <= 8'd0;
            shadow_q      <= 32'hFFFF_FFFF;
            seen_q        <= 8'd0;
            digits_q      <= 32'hFFFF_FFFF;
            frame_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            pattern_err_q <= 1'b0;
            cur_digit_q   <= 3'd0;
        end else begin
            seg_s1_q      <= seg_s1_d;
            seg_s2_q      <= seg_s2_d;
            seg_prev_q    <= seg_prev_d;
            an_s1_q       <= an_s1_d;
            an_s2_q       <= an_s2_d;
            an_prev_q     <= an_prev_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            seen_q        <= seen_d;
            digits_q      <= digits_d;
            frame_done_q  <= frame_done_d;
            frame_err_q   <= frame_err_d;
            pattern_err_q <= pattern_err_d;
            cur_digit_q   <= cur_digit_d;
        end
    end

    assign digits      = digits_q;
    assign frame_done  = frame_done_q;
    assign frame_err   = frame_err_q;
    assign pattern_err = pattern_err_q;
    assign cur_digit   = cur_digit_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture: scans digits across the anodes and checks
// capture latency, frame assembly, glitch rejection, error flags and reset behaviour.
`timescale 1ns/1ps
module tb_seven_seg_capture;

    localparam logic [6:0] S_BLANK = 7'b1111111;
    localparam logic [6:0] S_BAD   = 7'b1110000;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1011000, 7'b0000000, 7'b0010000};

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_in;
    logic [7:0]  an_in;
    logic [31:0] digits;
    logic        frame_done;
    logic        frame_err;
    logic        pattern_err;
    logic [2:0]  cur_digit;

    int errors = 0;
    int checks = 0;
    int fd_cnt = 0;
    int pe_cnt = 0;

    seven_seg_capture #(.STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .digits      (digits),
        .frame_done  (frame_done),
        .frame_err   (frame_err),
        .pattern_err (pattern_err),
        .cur_digit   (cur_digit)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            if (frame_done)  fd_cnt++;
            if (pattern_err) pe_cnt++;
        end
    end

    task automatic show(input logic [2:0] idx, input logic [6:0] seg, input int cycles);
        an_in  = ~(8'h01 << idx);
        seg_in = seg;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        an_in  = 8'hFF;
        seg_in = S_BLANK;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        show(3'd4, seg_tab[6], 5);
        checks++;
        if (digits !== 32'hFFFF_FFFF) begin
            errors++; $display("[TB] FAIL reset_digits: got %h expected ffffffff", digits);
        end
        checks++;
        if ({frame_done, frame_err, pattern_err} !== 3'b000) begin
            errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {frame_done, frame_err, pattern_err});
        end
        checks++;
        if (cur_digit !== 3'd0) begin
            errors++; $display("[TB] FAIL reset_cur_digit: got %0d expected 0", cur_digit);
        end
        rst    = 1'b1;
        an_in  = ~8'h04;
        seg_in = seg_tab[8];
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (cur_digit !== 3'd0) begin
                errors++; $display("[TB] FAIL early_capture cycle %0d: got %0d expected 0", k, cur_digit);
            end
        end
        @(negedge clk);
        checks++;
        if (cur_digit !== 3'd2) begin
            errors++; $display("[TB] FAIL capture_latency: got %0d expected 2", cur_digit);
        end
        repeat (4) @(negedge clk);
        idle(4);
        checks++;
        if (fd_cnt !== 0 || pe_cnt !== 0) begin
            errors++; $display("[TB] FAIL reset_no_pulses: got fd=%0d pe=%0d expected 0 0", fd_cnt, pe_cnt);
        end
    endtask

    task automatic test_full_frame();
        int fd0;
        int vals [8] = '{2, 0, 2, 4, 0, 1, 1, 5};
        fd0 = fd_cnt;
        for (int i = 0; i < 8; i++) show(3'(i), seg_tab[vals[i]], 10);
        idle(4);
        checks++;
        if (fd_cnt !== fd0 + 1) begin
            errors++; $display("[TB] FAIL full_frame_pulses: got %0d expected %0d", fd_cnt - fd0, 1);
        end
        checks++;
        if (digits !== 32'h5110_4202) begin
            errors++; $display("[TB] FAIL full_frame_digits: got %h expected 51104202", digits);
        end
        checks++;
        if (frame_err !== 1'b0 || cur_digit !== 3'd7) begin
            errors++; $display("[TB] FAIL full_frame_status: got err=%b cur=%0d expected err=0 cur=7", frame_err, cur_digit);
        end
    endtask

    task automatic test_glitch();
        show(3'd3, seg_tab[2], 3);
        idle(6);
        checks++;
        if (cur_digit !== 3'd7) begin
            errors++; $display("[TB] FAIL glitch_captured: got cur=%0d expected 7", cur_digit);
        end
        show(3'd3, seg_tab[2], 8);
        checks++;
        if (cur_digit !== 3'd3) begin
            errors++; $display("[TB] FAIL glitch_recapture: got cur=%0d expected 3", cur_digit);
        end
        idle(4);
    endtask

    task automatic test_bad_pattern();
        int fd0;
        int pe0;
        fd0 = fd_cnt;
        pe0 = pe_cnt;
        show(3'd5, S_BAD, 6);
        idle(4);
        checks++;
        if (pe_cnt !== pe0 + 1 || cur_digit !== 3'd5) begin
            errors++; $display("[TB] FAIL bad_pattern_pulse: got pulses=%0d cur=%0d expected 1 5", pe_cnt - pe0, cur_digit);
        end
        show(3'd0, seg_tab[1], 10);
        show(3'd1, seg_tab[2], 10);
        show(3'd2, seg_tab[3], 10);
        show(3'd4, seg_tab[4], 10);
        show(3'd6, seg_tab[6], 10);
        checks++;
        if (fd_cnt !== fd0) begin
            errors++; $display("[TB] FAIL bad_pattern_early_frame: got %0d expected 0", fd_cnt - fd0);
        end
        show(3'd7, seg_tab[7], 10);
        idle(4);
        checks++;
        if (fd_cnt !== fd0 + 1 || digits !== 32'h76E4_2321) begin
            errors++; $display("[TB] FAIL bad_pattern_frame: got pulses=%0d digits=%h expected 1 76e42321", fd_cnt - fd0, digits);
        end
        checks++;
        if (digits[23:20] !== 4'hE || frame_err !== 1'b1) begin
            errors++; $display("[TB] FAIL bad_pattern_frame_err: got nib=%h err=%b expected e 1", digits[23:20], frame_err);
        end
    endtask

    task automatic test_overwrite();
        int fd0;
        int pe0;
        fd0 = fd_cnt;
        pe0 = pe_cnt;
        show(3'd0, seg_tab[9], 10);
        show(3'd1, seg_tab[3], 10);
        an_in  = 8'hFC;
        seg_in = S_BAD;
        repeat (20) @(negedge clk);
        checks++;
        if (pe_cnt !== pe0 || cur_digit !== 3'd1) begin
            errors++; $display("[TB] FAIL multi_anode_capture: got pulses=%0d cur=%0d expected 0 1", pe_cnt - pe0, cur_digit);
        end
        show(3'd1, seg_tab[7], 10);
        show(3'd2, seg_tab[8], 10);
        show(3'd3, seg_tab[6], 10);
        show(3'd4, seg_tab[5], 10);
        show(3'd5, S_BLANK, 10);
        show(3'd6, seg_tab[0], 10);
        checks++;
        if (fd_cnt !== fd0) begin
            errors++; $display("[TB] FAIL overwrite_early_frame: got %0d expected 0", fd_cnt - fd0);
        end
        show(3'd7, seg_tab[1], 10);
        idle(4);
        checks++;
        if (fd_cnt !== fd0 + 1 || digits !== 32'h10F5_6879) begin
            errors++; $display("[TB] FAIL overwrite_frame: got pulses=%0d digits=%h expected 1 10f56879", fd_cnt - fd0, digits);
        end
        checks++;
        if (digits[7:4] !== 4'h7 || frame_err !== 1'b0) begin
            errors++; $display("[TB] FAIL overwrite_nibble: got nib=%h err=%b expected 7 0", digits[7:4], frame_err);
        end
    endtask

    task automatic test_reset_mid_frame();
        int fd0;
        for (int i = 0; i < 5; i++) show(3'(i), seg_tab[i + 1], 10);
        rst = 1'b0;
        idle(3);
        checks++;
        if (digits !== 32'hFFFF_FFFF || cur_digit !== 3'd0) begin
            errors++; $display("[TB] FAIL mid_reset_state: got digits=%h cur=%0d expected ffffffff 0", digits, cur_digit);
        end
        rst = 1'b1;
        idle(2);
        fd0 = fd_cnt;
        show(3'd5, seg_tab[0], 10);
        show(3'd6, seg_tab[1], 10);
        show(3'd7, seg_tab[2], 10);
        idle(4);
        checks++;
        if (fd_cnt !== fd0) begin
            errors++; $display("[TB] FAIL mid_reset_partial_frame: got %0d expected 0", fd_cnt - fd0);
        end
        show(3'd0, seg_tab[9], 10);
        show(3'd1, seg_tab[8], 10);
        show(3'd2, seg_tab[7], 10);
        show(3'd3, seg_tab[6], 10);
        checks++;
        if (fd_cnt !== fd0) begin
            errors++; $display("[TB] FAIL mid_reset_early_frame: got %0d expected 0", fd_cnt - fd0);
        end
        show(3'd4, seg_tab[5], 10);
        idle(4);
        checks++;
        if (fd_cnt !== fd0 + 1 || digits !== 32'h2105_6789) begin
            errors++; $display("[TB] FAIL mid_reset_frame: got pulses=%0d digits=%h expected 1 21056789", fd_cnt - fd0, digits);
        end
    endtask

    initial begin
        rst    = 1'b0;
        an_in  = 8'hFF;
        seg_in = S_BLANK;
        @(negedge clk);
        test_reset();
        test_full_frame();
        test_glitch();
        test_bad_pattern();
        test_overwrite();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
